// File: rtl/bm_defs.sv
// Shared widths, constants and the side-band payload for the disparity
// calculator (bm_calc_disp) and its divider step (bm_div_step).
package bm_defs;

    localparam int unsigned SAD_W       = 16;         // SAD input width
    localparam int unsigned IDX_W       = 5;          // index in 32-candidate window
    localparam int unsigned FRAC_W      = 4;          // 1/16 px output fraction
    localparam int unsigned UNIQ_SCALE  = 100;        // percent scale of uniq_ratio
    localparam int unsigned BM_LAT_DISP = 6;          // input-to-output latency

    localparam int unsigned RATIO_W = 8;
    localparam int unsigned DBASE_W = 8;
    localparam int unsigned BASE_W  = DBASE_W + 1;    // disp_base + idx1
    localparam int unsigned DENP_W  = SAD_W + 1;      // positive denominator
    localparam int unsigned REM_W   = SAD_W + 4;      // |l-r| << 3
    localparam int unsigned Q_W     = 4;              // quotient bits
    localparam int unsigned UNIQ_W  = 26;             // uniqueness products
    localparam int unsigned DISP_W  = 16;             // Q12.4 disparity

    // Per-pixel data that rides alongside the divider
    typedef struct packed {
        logic              sgn;       // l < r: vertex toward lower index
        logic              uniq_bad;  // failed uniqueness test
        logic              flat;      // den <= 0: no sub-pixel fit
        logic [BASE_W-1:0] base;      // disp_base + idx1
        logic [IDX_W-1:0]  idx2;      // second-best index (debug)
    } bm_side_t;

endpackage

// File: rtl/bm_div_step.sv
// One registered restoring-division step: compares the partial remainder
// with den << SHIFT, subtracts when it fits and sets quotient bit SHIFT.
// Payload (den, side-band) passes through. Stage registers clear when
// vld_i is low.
// Ports: clk, rst_n; vld_i stage valid; rem_i/den_i/q_i/side_i in;
//        rem_o/den_o/q_o/side_o registered out.
module bm_div_step
    import bm_defs::*;
#(
    parameter int unsigned SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld_i,
    input  logic [REM_W-1:0]  rem_i,
    input  logic [DENP_W-1:0] den_i,
    input  logic [Q_W-1:0]    q_i,
    input  bm_side_t          side_i,
    output logic [REM_W-1:0]  rem_o,
    output logic [DENP_W-1:0] den_o,
    output logic [Q_W-1:0]    q_o,
    output bm_side_t          side_o
);

    logic [REM_W-1:0]  den_sh_c;
    logic              ge_c;
    logic [REM_W-1:0]  rem_d,  rem_q;
    logic [DENP_W-1:0] den_d,  den_q;
    logic [Q_W-1:0]    q_d,    q_q;
    bm_side_t          side_d, side_q;

    // Trial subtraction; den << 3 still fits REM_W since den < 2^17
    always_comb begin
        den_sh_c = REM_W'(den_i) << SHIFT;
        ge_c     = (rem_i >= den_sh_c);
        rem_d    = '0;
        den_d    = '0;
        q_d      = '0;
        side_d   = '0;
        if (vld_i) begin
            rem_d     = ge_c ? (rem_i - den_sh_c) : rem_i;
            den_d     = den_i;
            q_d       = q_i;
            q_d[SHIFT] = ge_c;
            side_d    = side_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            den_q  <= '0;
            q_q    <= '0;
            side_q <= '0;
        end else begin
            rem_q  <= rem_d;
            den_q  <= den_d;
            q_q    <= q_d;
            side_q <= side_d;
        end
    end

    assign rem_o  = rem_q;
    assign den_o  = den_q;
    assign q_o    = q_q;
    assign side_o = side_q;

endmodule

// File: rtl/bm_calc_disp.sv
// Block-matching disparity calculator: uniqueness test, parabola-fit
// sub-pixel offset (4-step pipelined restoring divider) and Q12.4 output.
// Fixed 6-cycle latency, one pixel per cycle, no backpressure.
// Build option: define BM_SUBPIX_EN for the sub-pixel fit; without it the
// divider becomes plain delay registers and the fraction is always 0.
// Ports: clk, rst_n; vin + det_* pixel inputs; uniq_ratio, disp_base
//        quasi-static; disp (Q12.4), disp_ok, idx2_o, vout outputs.
module bm_calc_disp
    import bm_defs::*;
(
    input  logic               rst_n,
    input  logic               clk,
    input  logic               vin,
    input  logic [SAD_W-1:0]   det_min1,
    input  logic [SAD_W-1:0]   det_min2,
    input  logic [IDX_W-1:0]   det_idx1,
    input  logic [IDX_W-1:0]   det_idx2,
    input  logic [SAD_W-1:0]   det_l,
    input  logic [SAD_W-1:0]   det_r,
    input  logic [RATIO_W-1:0] uniq_ratio,
    input  logic [DBASE_W-1:0] disp_base,
    output logic [DISP_W-1:0]  disp,
    output logic               disp_ok,
    output logic [IDX_W-1:0]   idx2_o,
    output logic               vout
);

    localparam int unsigned DEN_W = SAD_W + 2;
    localparam int unsigned SUM_W = DISP_W + 1;
    localparam int unsigned NSTEP = 4;

    // Stage valid shift register
    logic [BM_LAT_DISP-1:0] vld_d, vld_q;

    always_comb begin
        vld_d = {vld_q[BM_LAT_DISP-2:0], vin};
    end

    // ---------------- S1: fit terms and uniqueness ----------------
    logic signed [DEN_W-1:0] den_c;
    logic                    flat_c;
    logic [UNIQ_W-1:0]       lhs_c, rhs_c;
    bm_side_t                side_s1_d, side_s1_q;

    always_comb begin
        den_c  = $signed({2'b00, det_l}) + $signed({2'b00, det_r})
               - $signed({1'b0, det_min1, 1'b0});
        flat_c = den_c[DEN_W-1] || (den_c == '0);
        lhs_c  = UNIQ_W'(det_min2) * UNIQ_W'(UNIQ_SCALE);
        rhs_c  = UNIQ_W'(det_min1) * (UNIQ_W'(UNIQ_SCALE) + UNIQ_W'(uniq_ratio));
        side_s1_d = '0;
        if (vin) begin
            side_s1_d.sgn      = (det_l < det_r);
            side_s1_d.uniq_bad = (uniq_ratio != '0) && (lhs_c < rhs_c);
            side_s1_d.flat     = flat_c;
            side_s1_d.base     = BASE_W'(disp_base) + BASE_W'(det_idx1);
            side_s1_d.idx2     = det_idx2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            side_s1_q <= '0;
        end else begin
            vld_q     <= vld_d;
            side_s1_q <= side_s1_d;
        end
    end

    // ---------------- S2..S5 ----------------
    bm_side_t         side_s [0:NSTEP];
    logic [Q_W-1:0]   q_fin;

    assign side_s[0] = side_s1_q;

`ifdef BM_SUBPIX_EN
    logic signed [SAD_W:0] num_c;
    logic [SAD_W:0]        abs_c;
    logic [REM_W-1:0]      rem_s1_d, rem_s1_q;
    logic [DENP_W-1:0]     den_s1_d, den_s1_q;

    // Numerator magnitude pre-scaled by 8 so the quotient is in 1/16 px
    always_comb begin
        num_c    = $signed({1'b0, det_l}) - $signed({1'b0, det_r});
        abs_c    = num_c[SAD_W] ? unsigned'(-num_c) : unsigned'(num_c);
        rem_s1_d = '0;
        den_s1_d = '0;
        if (vin) begin
            rem_s1_d = {abs_c, 3'b000};
            // Non-positive den is replaced by 0; its quotient is discarded
            den_s1_d = flat_c ? '0 : den_c[DENP_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_s1_q <= '0;
            den_s1_q <= '0;
        end else begin
            rem_s1_q <= rem_s1_d;
            den_s1_q <= den_s1_d;
        end
    end

    logic [REM_W-1:0]  rem_s [0:NSTEP];
    logic [DENP_W-1:0] den_s [0:NSTEP];
    logic [Q_W-1:0]    q_s   [0:NSTEP];

    assign rem_s[0] = rem_s1_q;
    assign den_s[0] = den_s1_q;
    assign q_s[0]   = '0;

    // Quotient MSB first: step g resolves bit 3-g
    for (genvar g = 0; g < NSTEP; g++) begin : g_step
        bm_div_step #(.SHIFT(NSTEP - 1 - g)) u_step (
            .clk    (clk),
            .rst_n  (rst_n),
            .vld_i  (vld_q[g]),
            .rem_i  (rem_s[g]),
            .den_i  (den_s[g]),
            .q_i    (q_s[g]),
            .side_i (side_s[g]),
            .rem_o  (rem_s[g+1]),
            .den_o  (den_s[g+1]),
            .q_o    (q_s[g+1]),
            .side_o (side_s[g+1])
        );
    end

    assign q_fin = q_s[NSTEP];
`else
    bm_side_t dly_d [0:NSTEP-1];
    bm_side_t dly_q [0:NSTEP-1];

    // Latency-matching delay line in place of the divider
    always_comb begin
        for (int i = 0; i < NSTEP; i++) begin
            dly_d[i] = vld_q[i] ? side_s[i] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSTEP; i++) dly_q[i] <= '0;
        end else begin
            for (int i = 0; i < NSTEP; i++) dly_q[i] <= dly_d[i];
        end
    end

    for (genvar g = 0; g < NSTEP; g++) begin : g_dly
        assign side_s[g+1] = dly_q[g];
    end

    assign q_fin = '0;
`endif

    // ---------------- S6: fraction, saturation, output ----------------
    bm_side_t                 s5_c;
    logic [Q_W-1:0]           q_cl_c;
    logic signed [FRAC_W:0]   frac_c;
    logic signed [SUM_W-1:0]  sum_c;
    logic [DISP_W-1:0]        disp_d,    disp_q;
    logic                     disp_ok_d, disp_ok_q;
    logic [IDX_W-1:0]         idx2_d,    idx2_q;

    always_comb begin
        s5_c   = side_s[NSTEP];
        // Guard only: q <= 8 whenever c is the true minimum
        q_cl_c = (q_fin > Q_W'(8)) ? Q_W'(8) : q_fin;
        if (s5_c.flat) begin
            frac_c = '0;
        end else if (s5_c.sgn) begin
            frac_c = -$signed({1'b0, q_cl_c});
        end else begin
            frac_c = $signed({1'b0, q_cl_c});
        end
        sum_c = $signed({1'b0, DISP_W'(s5_c.base) << FRAC_W}) + SUM_W'(frac_c);

        disp_d    = '0;
        disp_ok_d = 1'b0;
        idx2_d    = '0;
        if (vld_q[NSTEP]) begin
            idx2_d    = s5_c.idx2;
            disp_ok_d = !s5_c.uniq_bad;
            // base 0 with a negative fraction saturates to 0
            if (!s5_c.uniq_bad) begin
                disp_d = sum_c[SUM_W-1] ? '0 : sum_c[DISP_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q    <= '0;
            disp_ok_q <= 1'b0;
            idx2_q    <= '0;
        end else begin
            disp_q    <= disp_d;
            disp_ok_q <= disp_ok_d;
            idx2_q    <= idx2_d;
        end
    end

    assign disp    = disp_q;
    assign disp_ok = disp_ok_q;
    assign idx2_o  = idx2_q;
    assign vout    = vld_q[BM_LAT_DISP-1];

endmodule

// File: tb/tb_bm_calc_disp.sv
// Directed self-checking bench for bm_calc_disp: single-pixel vectors with
// hand-computed results, a bubbly 32-pixel stream against a reference
// model, and a mid-stream reset. Expected sub-pixel values follow the
// BM_SUBPIX_EN build option.
module tb_bm_calc_disp;

`ifdef BM_SUBPIX_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vin = 1'b0;
    logic [15:0] det_min1 = '0, det_min2 = '0, det_l = '0, det_r = '0;
    logic [4:0]  det_idx1 = '0, det_idx2 = '0;
    logic [7:0]  uniq_ratio = '0, disp_base = '0;
    logic [15:0] disp;
    logic        disp_ok;
    logic [4:0]  idx2_o;
    logic        vout;

    int          n_chk  = 0;
    int          n_pass = 0;
    int unsigned cyc    = 0;

    bm_calc_disp dut (
        .rst_n      (rst_n),
        .clk        (clk),
        .vin        (vin),
        .det_min1   (det_min1),
        .det_min2   (det_min2),
        .det_idx1   (det_idx1),
        .det_idx2   (det_idx2),
        .det_l      (det_l),
        .det_r      (det_r),
        .uniq_ratio (uniq_ratio),
        .disp_base  (disp_base),
        .disp       (disp),
        .disp_ok    (disp_ok),
        .idx2_o     (idx2_o),
        .vout       (vout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic set_pix(input int l, input int c, input int r, input int m2,
                           input int i1, input int i2, input int ratio, input int base);
        det_l      = 16'(l);
        det_min1   = 16'(c);
        det_r      = 16'(r);
        det_min2   = 16'(m2);
        det_idx1   = 5'(i1);
        det_idx2   = 5'(i2);
        uniq_ratio = 8'(ratio);
        disp_base  = 8'(base);
    endtask

    // Reference: integer division truncates toward zero
    task automatic model(input int l, input int c, input int r, input int m2,
                         input int i1, input int ratio, input int base,
                         output int ed, output int eo);
        int num, den, frac;
        bit bad;
        bad  = (ratio != 0) && (m2 * 100 < c * (100 + ratio));
        num  = l - r;
        den  = l + r - 2 * c;
        frac = 0;
        if (SUB && den > 0) begin
            frac = (8 * num) / den;
            if (frac > 8)  frac = 8;
            if (frac < -8) frac = -8;
        end
        ed = (base + i1) * 16 + frac;
        if (ed < 0) ed = 0;
        eo = bad ? 0 : 1;
        if (bad) ed = 0;
    endtask

    // One isolated pixel; result must appear exactly 6 cycles later
    task automatic pix(input string tag, input int l, input int c, input int r,
                       input int m2, input int i1, input int i2, input int ratio,
                       input int base, input int exp_disp, input int exp_ok);
        @(negedge clk);
        set_pix(l, c, r, m2, i1, i2, ratio, base);
        vin = 1'b1;
        @(negedge clk);
        vin = 1'b0;
        repeat (4) @(negedge clk);
        chk({tag, "_vout_early"}, 32'(vout), 0);
        @(negedge clk);
        chk({tag, "_vout"}, 32'(vout), 1);
        chk({tag, "_disp"}, 32'(disp), 32'(exp_disp));
        chk({tag, "_ok"},   32'(disp_ok), 32'(exp_ok));
        chk({tag, "_idx2"}, 32'(idx2_o), 32'(i2));
    endtask

    typedef struct {
        int unsigned t;
        int          disp;
        int          ok;
        int          idx2;
    } exp_t;

    exp_t sb[$];

    initial begin
        int sent, guard;
        int l, c, r, m2, i1, i2, mn, ed, eo;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_vout", 32'(vout), 0);
        chk("rst_disp", 32'(disp), 0);
        chk("rst_ok",   32'(disp_ok), 0);
        chk("rst_idx2", 32'(idx2_o), 0);
        rst_n = 1'b1;

        // Directed vectors
        pix("t_centre",  100,  50, 100, 200, 10,  3, 15,   0, 160, 1);
        pix("t_left",    100,  50, 150, 200, 10,  7, 15,   0, SUB ? 158 : 160, 1);
        pix("t_right",   150,  50, 100, 200, 10, 11, 15,   0, SUB ? 162 : 160, 1);
        pix("t_full",    200,   0,   0, 500, 10, 21, 15,  20, SUB ? 488 : 480, 1);
        pix("t_notuniq", 200, 100, 200, 110,  5,  9, 15,   0,   0, 0);
        pix("t_ratio0",  200, 100, 200, 110,  5,  9,  0,   0,  80, 1);
        pix("t_uniq_eq", 200, 100, 200, 115,  5,  6, 15,   0,  80, 1);
        pix("t_flat",     40,  40,  40, 100,  7,  2, 15,   0, 112, 1);
        pix("t_m1eqm2",   40,  40,  40,  40,  7,  2,  1,   0,   0, 0);
        pix("t_dneg",     10,  50,  10,1000, 12,  4, 15,   0, 192, 1);
        pix("t_sat0",    100,  50, 150, 200,  0,  1, 15,   0,   0, 1);
        pix("t_trunc_p",  90,   0,  10, 500,  4, 30, 15,   0, SUB ?  70 :  64, 1);
        pix("t_trunc_n",  10,   0,  90, 500,  4, 30, 15,   0, SUB ?  58 :  64, 1);
        pix("t_trunc_z", 100,   0,  90, 500, 10,  0, 15,   0, 160, 1);
        pix("t_max",     200,   0,   0, 500, 31, 31, 15, 255, SUB ? 4584 : 4576, 1);

        // Stream with random bubbles against the model
        sent  = 0;
        guard = 0;
        while ((sent < 32 || sb.size() != 0) && guard < 300) begin
            @(negedge clk);
            guard++;
            if (sb.size() != 0 && sb[0].t == cyc) begin
                chk("s_vout", 32'(vout), 1);
                chk("s_disp", 32'(disp), 32'(sb[0].disp));
                chk("s_ok",   32'(disp_ok), 32'(sb[0].ok));
                chk("s_idx2", 32'(idx2_o), 32'(sb[0].idx2));
                void'(sb.pop_front());
            end else begin
                chk("s_idle", 32'(vout), 0);
            end
            if (sent < 32 && $urandom_range(3, 0) != 0) begin
                l  = $urandom_range(4000, 0);
                r  = $urandom_range(4000, 0);
                mn = (l < r) ? l : r;
                c  = mn - $urandom_range(mn, 0);
                m2 = c + $urandom_range(c / 4 + 20, 0);
                i1 = $urandom_range(31, 0);
                i2 = $urandom_range(31, 0);
                set_pix(l, c, r, m2, i1, i2, 15, 3);
                vin = 1'b1;
                model(l, c, r, m2, i1, 15, 3, ed, eo);
                sb.push_back('{cyc + 6, ed, eo, i2});
                sent++;
            end else begin
                vin = 1'b0;
            end
        end
        vin = 1'b0;
        chk("s_drain", 32'(sb.size()), 0);

        // Mid-stream reset with pixels in flight
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            set_pix(100, 50, 100, 200, 9, 5, 15, 0);
            vin = 1'b1;
        end
        @(negedge clk);
        chk("r_pre_vout", 32'(vout), 1);
        vin   = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("r_vout", 32'(vout), 0);
        chk("r_disp", 32'(disp), 0);
        chk("r_ok",   32'(disp_ok), 0);
        chk("r_idx2", 32'(idx2_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("r_stale", 32'(vout), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
